// File: rtl/fir_cfg_sequencer.sv
// fir_cfg_sequencer: programs FIR taps, data length and ap_start over AXI-Lite,
// then polls ap_done until it is set or the poll timeout expires.
module fir_cfg_sequencer #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter int POLL_GAP    = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                        axis_clk,
   input  logic                        axis_rst_n,
   input  logic                        start,
   input  logic [pDATA_WIDTH-1:0]      len,
   output logic [$clog2(Tape_Num)-1:0] coef_idx,
   input  logic [pDATA_WIDTH-1:0]      coef_data,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic                        awvalid,
   output logic [pADDR_WIDTH-1:0]      awaddr,
   input  logic                        awready,
   output logic                        wvalid,
   output logic [pDATA_WIDTH-1:0]      wdata,
   input  logic                        wready,
   output logic                        arvalid,
   output logic [pADDR_WIDTH-1:0]      araddr,
   input  logic                        arready,
   input  logic                        rvalid,
   input  logic [pDATA_WIDTH-1:0]      rdata,
   output logic                        rready
);
   localparam int CW = $clog2(Tape_Num);
   localparam int IW = $clog2(Tape_Num + 2);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
   localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, POLL_AR = 3'd2, POLL_R = 3'd3, GAP = 3'd4, DONE = 3'd5;
   localparam logic [IW-1:0] TAPS = IW'(Tape_Num);
   localparam logic [IW-1:0] LAST = IW'(Tape_Num + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
   localparam logic [GW-1:0] GLAST = GW'(POLL_GAP - 1);
   localparam logic [pADDR_WIDTH-1:0] TAP_BASE = pADDR_WIDTH'(64);
   localparam logic [pADDR_WIDTH-1:0] LEN_ADDR = pADDR_WIDTH'(16);
   logic [2:0]             state;
   logic [IW-1:0]          widx, widx_n;
   logic [pDATA_WIDTH-1:0] len_q, l_data;
   logic [pADDR_WIDTH-1:0] l_addr;
   logic [TW-1:0]          tcnt, tsat;
   logic [GW-1:0]          gcnt;
   logic                   aw_left, w_left;
   logic                   rdata_unused;
   assign rdata_unused = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};
   // widx names the write to launch next; in IDLE it rests at 0 so start can launch tap 0 at once
   always_comb begin
      widx_n  = widx + 1'b1;
      aw_left = awvalid & ~awready;
      w_left  = wvalid & ~wready;
      tsat    = tcnt == TMAX ? tcnt : tcnt + 1'b1;
      l_addr  = widx < TAPS ? TAP_BASE + pADDR_WIDTH'({widx, 2'b00}) : widx == TAPS ? LEN_ADDR : '0;
      l_data  = widx < TAPS ? coef_data : widx == TAPS ? len_q : pDATA_WIDTH'(1);
   end
   always_ff @(posedge axis_clk or negedge axis_rst_n)
      if (!axis_rst_n) begin
         state    <= IDLE;
         widx     <= '0;
         coef_idx <= '0;
         len_q    <= '0;
         tcnt     <= '0;
         gcnt     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         awvalid  <= 1'b0;
         awaddr   <= '0;
         wvalid   <= 1'b0;
         wdata    <= '0;
         arvalid  <= 1'b0;
         araddr   <= '0;
         rready   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state   <= WR;
               busy    <= 1'b1;
               err     <= 1'b0;
               len_q   <= len;
               awvalid <= 1'b1;
               wvalid  <= 1'b1;
               awaddr  <= l_addr;
               wdata   <= l_data;
            end
            WR: if (!awvalid && !wvalid) begin
               awvalid <= 1'b1;
               wvalid  <= 1'b1;
               awaddr  <= l_addr;
               wdata   <= l_data;
            end else begin
               if (awready) awvalid <= 1'b0;
               if (wready) wvalid <= 1'b0;
               // both channels have handshaken: retire this write, line up the next tap
               if (!aw_left && !w_left) begin
                  coef_idx <= widx_n < TAPS ? CW'(widx_n) : '0;
                  widx     <= widx == LAST ? '0 : widx_n;
                  if (widx == LAST) begin
                     state   <= POLL_AR;
                     tcnt    <= '0;
                     arvalid <= 1'b1;
                     araddr  <= '0;
                  end
               end
            end
            POLL_AR: begin
               tcnt <= tsat;
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= POLL_R;
               end
            end
            POLL_R: begin
               tcnt <= tsat;
               if (rvalid) begin
                  rready <= 1'b0;
                  done   <= rdata[1];
                  gcnt   <= '0;
                  state  <= rdata[1] ? DONE : GAP;
               end
            end
            GAP: begin
               tcnt <= tsat;
               gcnt <= gcnt + 1'b1;
               // timeout is only honoured here, so a read in flight always completes
               if (tcnt == TMAX) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (gcnt == GLAST) begin
                  arvalid <= 1'b1;
                  state   <= POLL_AR;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// tb_fir_cfg_sequencer: directed vector table plus randomized runs against a
// scoreboard that predicts write beats, poll timing, done cycle and err.
module tb_fir_cfg_sequencer;
   localparam int AW = 12, DW = 32, TAPS = 11, GAP = 4, TO = 20;
   localparam int CW = $clog2(TAPS);
   typedef struct {
      int len; int n_busy; int hold; int pa; int pw; int par; int pr;
      bit plain; int exp_reads; bit exp_err;
   } vec_t;
   logic axis_clk = 0, axis_rst_n = 1, start = 0;
   logic [DW-1:0] len = 0, coef_data = 0, rdata = 0;
   logic [CW-1:0] coef_idx;
   logic busy, done, err, awvalid, wvalid, arvalid, rready;
   logic awready = 0, wready = 0, arready = 0, rvalid = 0;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata;
   int checks = 0, errors = 0;
   logic [DW-1:0] coefs [TAPS];
   logic [AW-1:0] exp_addr [TAPS+2];
   logic [DW-1:0] exp_data [TAPS+2];
   int cyc = 0, awn, wn, arn, rn, pend, t0, exp_ar, exp_done, hold_at;
   vec_t cur;
   bit exp_err, seen_done;
   logic err_at_done;
   logic p_awvalid, p_wvalid, p_arvalid, p_aw_hs, p_w_hs, p_ar_hs, p_r_hs, p_done;
   logic [AW-1:0] p_awaddr;
   logic [DW-1:0] p_wdata;
   vec_t tbl [5];

   fir_cfg_sequencer #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TAPS), .POLL_GAP(GAP), .TIMEOUT_CYC(TO)) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .len(len), .coef_idx(coef_idx),
      .coef_data(coef_data), .busy(busy), .done(done), .err(err), .awvalid(awvalid), .awaddr(awaddr),
      .awready(awready), .wvalid(wvalid), .wdata(wdata), .wready(wready), .arvalid(arvalid),
      .araddr(araddr), .arready(arready), .rvalid(rvalid), .rdata(rdata), .rready(rready));

   always #5 axis_clk = ~axis_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic hist_clear();
      {p_awvalid, p_wvalid, p_arvalid, p_aw_hs, p_w_hs, p_ar_hs, p_r_hs, p_done} = '0;
      p_awaddr = '0;
      p_wdata = '0;
   endtask

   // One cycle: check DUT outputs at the falling edge, then choose slave inputs for the next rising edge
   task automatic step();
      logic aw_hs, w_hs, ar_hs, r_hs;
      int rel;
      @(negedge axis_clk);
      cyc++;
      coef_data = coef_idx < TAPS ? coefs[coef_idx] : '0;
      if (p_awvalid && !p_aw_hs) begin chk("aw_hold", awvalid, 1); chk("aw_stable", awaddr, p_awaddr); end
      if (p_wvalid && !p_w_hs) begin chk("w_hold", wvalid, 1); chk("w_stable", wdata, p_wdata); end
      if (p_aw_hs) chk("aw_drop", awvalid, 0);
      if (p_w_hs) chk("w_drop", wvalid, 0);
      if (awvalid && !p_awvalid) begin chk("aw_w_rise", wvalid, 1); chk("aw_order", awn, wn); end
      if (wvalid && !p_wvalid) chk("w_aw_rise", awvalid, 1);
      if (p_arvalid && !p_ar_hs) chk("ar_hold", arvalid, 1);
      if (p_ar_hs) chk("ar_drop", arvalid, 0);
      if (arvalid && !p_arvalid) chk("ar_time", cyc, exp_ar);
      if (p_done) begin chk("done_pulse", done, 0); chk("busy_fall", busy, 0); end
      if (done) begin
         chk("done_time", cyc, exp_done);
         chk("err", err, exp_err);
         chk("rd_idle", {pend != 0, arvalid, rready}, 0);
         chk("busy_at_done", busy, 1);
         seen_done = 1;
         err_at_done = err;
      end
      awready = $urandom_range(99) < cur.pa;
      wready = $urandom_range(99) < cur.pw && !(wn == cur.hold && (awn <= cur.hold || cyc < hold_at));
      arready = $urandom_range(99) < cur.par;
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      ar_hs = arvalid && arready;
      if (aw_hs) begin
         if (awn < TAPS + 2) chk("awaddr", awaddr, exp_addr[awn]); else chk("aw_extra", awn, TAPS + 1);
         if (awn == cur.hold) hold_at = cyc + 3;
         awn++;
      end
      if (w_hs) begin
         if (wn < TAPS + 2) chk("wdata", wdata, exp_data[wn]); else chk("w_extra", wn, TAPS + 1);
         if (wn == cur.hold && cur.pw == 100) chk("w_delay", cyc, hold_at);
         wn++;
      end
      if ((aw_hs || w_hs) && awn == TAPS + 2 && wn == TAPS + 2) begin t0 = cyc + 1; exp_ar = cyc + 1; end
      // read data only for reads accepted in earlier cycles; held until taken
      if (!(rvalid && !p_r_hs)) begin
         rvalid = pend > 0 && $urandom_range(99) < cur.pr;
         if (rvalid) rdata = rn < cur.n_busy ? (cur.plain ? 32'h4 : ($urandom & ~32'h2)) : (cur.plain ? 32'h2 : ($urandom | 32'h2));
      end
      r_hs = rvalid && rready;
      if (r_hs) begin
         pend--;
         rn++;
         rel = cyc - t0;
         if (rdata[1]) begin exp_done = cyc + 1; exp_err = 0; end
         else if (rel + GAP >= TO) begin exp_done = t0 + (rel + 1 > TO ? rel + 1 : TO) + 1; exp_err = 1; end
         else exp_ar = cyc + GAP + 1;
      end
      if (ar_hs) begin chk("araddr", araddr, 0); chk("ar_after_wr", wn, TAPS + 2); pend++; arn++; end
      p_awvalid = awvalid; p_wvalid = wvalid; p_arvalid = arvalid; p_done = done;
      p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs; p_r_hs = r_hs;
      p_awaddr = awaddr; p_wdata = wdata;
   endtask

   task automatic idle_check(input string name);
      logic act;
      act = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         act = act | busy | awvalid | wvalid | arvalid | rready | done;
      end
      chk(name, act, 0);
   endtask

   task automatic prep(input vec_t v);
      cur = v;
      for (int i = 0; i < TAPS; i++) begin
         coefs[i] = v.plain ? DW'(i + 1) : $urandom;
         exp_addr[i] = AW'(64 + 4 * i);
         exp_data[i] = coefs[i];
      end
      exp_addr[TAPS] = 12'h010; exp_data[TAPS] = v.len;
      exp_addr[TAPS+1] = 12'h000; exp_data[TAPS+1] = 32'h1;
      len = v.len;
      awn = 0; wn = 0; arn = 0; rn = 0; pend = 0; hold_at = 0;
      t0 = -1; exp_ar = -1; exp_done = -1; exp_err = 0; seen_done = 0; err_at_done = 'x;
      rvalid = 0;
      coef_data = coef_idx < TAPS ? coefs[coef_idx] : '0;
   endtask

   task automatic run(input vec_t v);
      int sk;
      prep(v);
      sk = $urandom_range(20, 2);
      start = 1;
      step();
      start = 0;
      chk("start_resp", {busy, awvalid, wvalid, err}, 4'b1110);
      for (int i = 1; i < 3000 && !seen_done; i++) begin
         start = i == sk;
         step();
      end
      start = 0;
      chk("done_seen", seen_done, 1);
      chk("aw_beats", awn, TAPS + 2);
      chk("w_beats", wn, TAPS + 2);
      if (v.exp_reads >= 0) begin
         chk("tbl_reads", arn, v.exp_reads);
         chk("tbl_err", err_at_done, v.exp_err);
      end
      step();
      idle_check("no_requeue");
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{600, 2, -1, 100, 100, 100, 100, 1'b1, 3, 1'b0};
      tbl[1] = '{600, 255, -1, 100, 100, 100, 100, 1'b1, 4, 1'b1};
      tbl[2] = '{7, 0, 5, 100, 100, 100, 100, 1'b1, 1, 1'b0};
      tbl[3] = '{600, 1, -1, 100, 100, 100, 100, 1'b1, 2, 1'b0};
      tbl[4] = '{600, 3, -1, 100, 100, 100, 100, 1'b1, 4, 1'b0};
      cur = tbl[0];
      for (int i = 0; i < TAPS; i++) coefs[i] = '0;
      hist_clear();
      #1 axis_rst_n = 0;
      #1 chk("rst_state", {busy, done, err, awvalid, wvalid, arvalid, rready}, 0);
      chk("rst_regs", {awaddr, araddr, coef_idx}, 0);
      chk("rst_wdata", wdata, 0);
      prep(tbl[0]);
      repeat (3) step();
      axis_rst_n = 1;
      idle_check("post_rst_quiet");
      for (int i = 0; i < 5; i++) run(tbl[i]);
      // reset pulsed in the middle of the tap-7 write
      prep(tbl[0]);
      start = 1;
      step();
      start = 0;
      for (int i = 0; i < 200 && !(awvalid && awaddr == 12'h05C); i++) begin
         start = i == 4;
         step();
      end
      start = 0;
      chk("tap7_seen", {awvalid, awaddr}, {1'b1, 12'h05C});
      #2 axis_rst_n = 0;
      #1 chk("rst_mid", {busy, done, err, awvalid, wvalid, arvalid, rready}, 0);
      chk("rst_mid_regs", {awaddr, coef_idx}, 0);
      chk("rst_mid_wdata", wdata, 0);
      hist_clear();
      repeat (2) step();
      axis_rst_n = 1;
      idle_check("rst_mid_quiet");
      for (int r = 0; r < 14; r++) begin
         v.len = $urandom;
         v.n_busy = $urandom_range(5);
         v.hold = $urandom_range(1) ? int'($urandom_range(TAPS - 1)) : -1;
         v.pa = $urandom_range(100, 30);
         v.pw = $urandom_range(100, 30);
         v.par = $urandom_range(100, 30);
         v.pr = $urandom_range(100, 20);
         v.plain = 0;
         v.exp_reads = -1;
         v.exp_err = 0;
         run(v);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_cfg_sequencer.md
FIR_CFG_SEQUENCER -- requirements
Module: fir_cfg_sequencer

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 SHALL have parameter Tape_Num, default 11, number of tap coefficients to program.
REQ-004 SHALL have parameter POLL_GAP, default 4, idle cycles between status polls.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65535, maximum cycles allowed for the FIR to report done.
REQ-006 SHALL have port axis_clk  input  1  clock; all logic on the rising edge.
REQ-007 SHALL have port axis_rst_n  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have port start  input  1  launch request, sampled only when busy=0.
REQ-009 SHALL have port len  input  pDATA_WIDTH  data length written to FIR register 0x10.
REQ-010 SHALL have port coef_idx  output  $clog2(Tape_Num)  index of the coefficient being fetched.
REQ-011 SHALL have port coef_data  input  pDATA_WIDTH  coefficient for coef_idx, valid in the same cycle.
REQ-012 SHALL have ports busy, done, err  output  1 each: sequence active; 1-cycle completion pulse; sticky timeout flag.
REQ-013 SHALL have AXI-Lite master write ports awvalid(out,1), awaddr(out,pADDR_WIDTH), awready(in,1), wvalid(out,1), wdata(out,pDATA_WIDTH), wready(in,1).
REQ-014 SHALL have AXI-Lite master read ports arvalid(out,1), araddr(out,pADDR_WIDTH), arready(in,1), rvalid(in,1), rdata(in,pDATA_WIDTH), rready(out,1).

Function
REQ-015 SHALL drive all outputs from registers; combinational paths from inputs to outputs are prohibited.
REQ-016 SHALL implement states IDLE, WR, POLL_AR, POLL_R, GAP, DONE.
REQ-017 IDLE: start=1 latches len, clears err, sets the write index to 0, and enters WR; awvalid/wvalid assert in the next cycle.
REQ-018 SHALL perform Tape_Num+2 writes in order: tap i at address 0x40+4*i with data coef_data (i=0..Tape_Num-1), then len to 0x10, then 0x00000001 to 0x00.
REQ-019 coef_idx SHALL equal the current tap index; coef_data SHALL be captured into wdata in the cycle awvalid/wvalid first rise for that write.
REQ-020 WR: awvalid and wvalid SHALL rise together; each SHALL drop independently in the cycle after its own handshake (valid&ready); the next write SHALL start only after both handshakes complete.
REQ-021 awaddr/wdata SHALL remain stable while the corresponding valid is high.
REQ-022 After the ap_start write completes: clear the timeout counter and enter POLL_AR.
REQ-023 POLL_AR: arvalid=1, araddr=0x00 held until arready=1; then enter POLL_R.
REQ-024 POLL_R: rready=1; on rvalid=1, if rdata[1] (ap_done)=1 enter DONE, else enter GAP.
REQ-025 GAP: wait POLL_GAP cycles, then re-enter POLL_AR.
REQ-026 The timeout counter SHALL increment every cycle in POLL_AR/POLL_R/GAP and saturate at TIMEOUT_CYC.
REQ-027 In GAP only, when the counter reaches TIMEOUT_CYC: set err=1 and enter DONE; an in-flight read handshake SHALL never be abandoned.
REQ-028 DONE: assert done=1 for exactly one cycle, then return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-031 err SHALL hold until the next accepted start.
REQ-032 If awready/wready arrive in the same cycle, both SHALL be accepted; ready arriving before the other SHALL NOT cause a duplicate beat.

Reset
REQ-033 axis_rst_n=0 SHALL force IDLE and set busy, done, err, awvalid, wvalid, arvalid, rready to 0, all address/data/counter registers to 0, and coef_idx to 0, with immediate effect including mid-sequence.
REQ-034 After reset release, no AXI-Lite transaction SHALL start until an accepted start.

Verification
REQ-035 Tape_Num=11, len=600, coef_data=idx+1, slave always ready, start pulse -> 13 writes: 0x40..0x68 with data 1..11, 0x10<-600, 0x00<-1; then arvalid with araddr=0x00.
REQ-036 Slave returns rdata=0x4 twice, then 0x2 -> 3 reads, each after a 4-cycle GAP; done pulses once; err=0; busy falls in the same cycle done falls.
REQ-037 Slave delays wready 3 cycles after awready on tap 5 -> awvalid drops after its handshake; exactly one AW and one W beat; tap 6 write starts only after wready.
REQ-038 TIMEOUT_CYC=20, status rdata always 0x4 -> err=1 and done pulses once, no read left outstanding; next start clears err.
REQ-039 start pulsed again while busy; axis_rst_n pulsed low during the tap-7 write -> second start ignored; all valids 0 immediately; IDLE after release; no AXI activity without a new start.
